apb_bridge_mux: RTL and testbench

APB_BRIDGE_MUX -- requirements
Module: apb_bridge_mux

---
 rtl/apb_bridge_mux.sv | 169 ++++++++++++++++
 tb/tb_apb_bridge_mux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_mux.sv
// apb_bridge_mux: single-master CPU request to APB bridge with address decode
// onto NUM_SLV slave channels. Each slave owns a 2**REGION_LOG2 byte region
// starting at BASE_ADDR; accesses outside the window complete with err=1.
//
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN
//   defined   -> ACCESS aborts with err after TIMEOUT_CYC not-ready cycles
//   undefined -> ACCESS waits for PREADY indefinitely (no counter)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer in flight, APB select/enable low
// SETUP  | PSEL[idx]=1, PENABLE=0, one cycle
// ACCESS | PSEL[idx]=1, PENABLE=1, wait for PREADY[idx] (or timeout)
// ERR    | unmapped address, one-cycle ready with err=1, no PSEL

module apb_bridge_mux #(
   parameter int          NUM_SLV     = 4,
   parameter int          DATA_W      = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          REGION_LOG2 = 12,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic                        PCLK,
   input  logic                        PRESET,
   input  logic                        transfer,
   input  logic                        write,
   input  logic [31:0]                 addr,
   input  logic [DATA_W-1:0]           wdata,
   output logic [DATA_W-1:0]           rdata,
   output logic                        ready,
   output logic                        err,
   output logic [31:0]                 PADDR,
   output logic [DATA_W-1:0]           PWDATA,
   output logic                        PWRITE,
   output logic                        PENABLE,
   output logic [NUM_SLV-1:0]          PSEL,
   input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
   input  logic [NUM_SLV-1:0]          PREADY,
   input  logic [NUM_SLV-1:0]          PSLVERR
);

   localparam int          DEC_W    = $clog2(NUM_SLV);
   localparam int          IDX_W    = (DEC_W > 0) ? DEC_W : 1;
   localparam int          HI_LSB   = REGION_LOG2 + DEC_W;
   localparam logic [31:0] HI_MASK  = (HI_LSB >= 32) ? 32'd0 : ~((32'd1 << HI_LSB) - 32'd1);
   localparam logic [31:0] IDX_MASK = (32'd1 << DEC_W) - 32'd1;

   // Reject configurations the decode and timer cannot represent.
   if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("apb_bridge_mux: illegal NUM_SLV or TIMEOUT_CYC");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;

   logic [31:0]         w_idx_full;
   logic [IDX_W-1:0]    w_idx;
   logic                w_mapped;
   logic [NUM_SLV-1:0]  w_onehot;
   logic                w_pready;
   logic                w_pslverr;
   logic [DATA_W-1:0]   w_prdata;
   logic                w_timeout;
   logic                w_ready;

   // Address decode: region index plus window match on the bits above it.
   always_comb begin
      w_idx_full = (addr >> REGION_LOG2) & IDX_MASK;
      w_idx      = w_idx_full[IDX_W-1:0];
      w_mapped   = (((addr ^ BASE_ADDR) & HI_MASK) == 32'd0) && (w_idx_full < 32'(NUM_SLV));
      w_onehot   = NUM_SLV'(1) << w_idx;
   end

   // Pick the selected slave's response; other slaves are ignored.
   always_comb begin
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      w_prdata  = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_pready  = PREADY[i];
            w_pslverr = PSLVERR[i];
            w_prdata  = PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_cnt;

   // Timeout fires once the counter has seen TIMEOUT_CYC not-ready cycles.
   always_comb begin
      w_timeout = (r_state == S_ACCESS) && !w_pready && (r_cnt == CNT_W'(TIMEOUT_CYC));
   end
`else
   // No timer in this build: ACCESS only ends on PREADY.
   always_comb begin
      w_timeout = 1'b0;
   end
`endif

   // Completion response; a real PREADY takes priority over a timeout.
   always_comb begin
      w_ready = (r_state == S_ERR) || ((r_state == S_ACCESS) && (w_pready || w_timeout));
      ready   = w_ready;
      err     = (r_state == S_ERR) ||
                ((r_state == S_ACCESS) && w_pready && w_pslverr) ||
                w_timeout;
      rdata   = ((r_state == S_ACCESS) && w_pready && !PWRITE) ? w_prdata : '0;
   end

   // Bridge FSM with registered APB outputs; new requests are accepted in
   // IDLE or in any ready cycle, so back-to-back transfers skip IDLE.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         PADDR   <= '0;
         PWDATA  <= '0;
         PWRITE  <= 1'b0;
         PENABLE <= 1'b0;
         PSEL    <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
         r_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            S_SETUP: begin
               PENABLE <= 1'b1;
               r_state <= S_ACCESS;
            end
            default: begin
               if ((r_state == S_ACCESS) && !w_ready) begin
`ifdef APB_BRIDGE_TIMEOUT_EN
                  r_cnt <= r_cnt + CNT_W'(1);
`endif
               end else if ((r_state == S_IDLE) || w_ready) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  if (!transfer) begin
                     r_state <= S_IDLE;
                  end else if (w_mapped) begin
                     PADDR   <= addr;
                     PWDATA  <= wdata;
                     PWRITE  <= write;
                     r_idx   <= w_idx;
                     PSEL    <= w_onehot;
                     r_state <= S_SETUP;
`ifdef APB_BRIDGE_TIMEOUT_EN
                     r_cnt   <= '0;
`endif
                  end else begin
                     r_state <= S_ERR;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_bridge_mux.sv
// tb_apb_bridge_mux: directed stimulus with a response scoreboard. Expected
// {err, rdata} pairs are queued as requests are issued and popped whenever
// the bridge pulses ready.

module tb_apb_bridge_mux;

   localparam int NS = 4;
   localparam int DW = 32;

   logic               PCLK;
   logic               PRESET;
   logic               transfer;
   logic               write;
   logic [31:0]        addr;
   logic [DW-1:0]      wdata;
   logic [DW-1:0]      rdata;
   logic               ready;
   logic               err;
   logic [31:0]        PADDR;
   logic [DW-1:0]      PWDATA;
   logic               PWRITE;
   logic               PENABLE;
   logic [NS-1:0]      PSEL;
   logic [NS*DW-1:0]   PRDATA;
   logic [NS-1:0]      PREADY;
   logic [NS-1:0]      PSLVERR;

   int n_checks = 0;
   int n_errors = 0;
   logic [32:0] sb_q[$];

   apb_bridge_mux #(
      .NUM_SLV     (NS),
      .DATA_W      (DW),
      .BASE_ADDR   (32'h1000_0000),
      .REGION_LOG2 (12),
      .TIMEOUT_CYC (4)
   ) u_dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .err      (err),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PENABLE  (PENABLE),
      .PSEL     (PSEL),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
      transfer = 1'b1;
      write    = w;
      addr     = a;
      wdata    = d;
   endtask

   task automatic expect_rsp(input logic e, input logic [31:0] d);
      sb_q.push_back({e, d});
   endtask

   // Scoreboard: every ready pulse must match the oldest queued response.
   always @(negedge PCLK) begin
      if (ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ready", 64'd1, 64'd0);
         end else begin
            chk("rsp", 64'({err, rdata}), 64'(sb_q.pop_front()));
         end
      end
   end

   initial begin
      PRESET   = 1'b0;
      transfer = 1'b0;
      write    = 1'b0;
      addr     = '0;
      wdata    = '0;
      PRDATA   = '0;
      PREADY   = '0;
      PSLVERR  = '0;
      repeat (3) tick();

      chk("rst_psel",    64'(PSEL),    64'd0);
      chk("rst_penable", 64'(PENABLE), 64'd0);
      chk("rst_paddr",   64'(PADDR),   64'd0);
      chk("rst_ready",   64'(ready),   64'd0);
      chk("rst_err",     64'(err),     64'd0);
      chk("rst_rdata",   64'(rdata),   64'd0);
      PRESET = 1'b1;
      tick();

      // Single write, slave1 ready immediately.
      PREADY = 4'b0010;
      req(1'b1, 32'h1000_1004, 32'hDEAD_BEEF);
      expect_rsp(1'b0, 32'h0);
      tick();
      transfer = 1'b0;
      chk("wr_setup_psel",    64'(PSEL),    64'h2);
      chk("wr_setup_penable", 64'(PENABLE), 64'd0);
      chk("wr_setup_paddr",   64'(PADDR),   64'h1000_1004);
      chk("wr_setup_pwdata",  64'(PWDATA),  64'hDEAD_BEEF);
      chk("wr_setup_pwrite",  64'(PWRITE),  64'd1);
      chk("wr_setup_ready",   64'(ready),   64'd0);
      tick();
      chk("wr_acc_penable", 64'(PENABLE), 64'd1);
      chk("wr_acc_psel",    64'(PSEL),    64'h2);
      chk("wr_acc_ready",   64'(ready),   64'd1);
      chk("wr_acc_err",     64'(err),     64'd0);
      tick();
      chk("wr_idle_psel", 64'(PSEL), 64'd0);

      // Read slave3 with three wait states; unselected slave0 ready is ignored.
      PREADY = 4'b0001;
      PRDATA[3*DW +: DW] = 32'h0000_00A5;
      PRDATA[0*DW +: DW] = 32'hBAD0_BAD0;
      req(1'b0, 32'h1000_3000, 32'h0);
      expect_rsp(1'b0, 32'h0000_00A5);
      tick();
      transfer = 1'b0;
      chk("rd_setup_psel", 64'(PSEL), 64'h8);
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) PREADY = 4'b1000;
         #1;
         chk("rd_acc_psel",    64'(PSEL),    64'h8);
         chk("rd_acc_penable", 64'(PENABLE), 64'd1);
         chk("rd_acc_ready",   64'(ready),   (i == 4) ? 64'd1 : 64'd0);
      end
      tick();
      PREADY = '0;

      // Unmapped read.
      req(1'b0, 32'h2000_0000, 32'h0);
      expect_rsp(1'b1, 32'h0);
      tick();
      transfer = 1'b0;
      chk("um_ready", 64'(ready), 64'd1);
      chk("um_err",   64'(err),   64'd1);
      chk("um_psel",  64'(PSEL),  64'd0);
      tick();
      chk("um_done_ready", 64'(ready), 64'd0);

      // Back-to-back writes; second slave reports PSLVERR.
      PREADY  = 4'b0101;
      PSLVERR = 4'b0100;
      req(1'b1, 32'h1000_0010, 32'h1111_1111);
      expect_rsp(1'b0, 32'h0);
      tick();
      transfer = 1'b0;
      chk("b2b_a_psel", 64'(PSEL), 64'h1);
      tick();
      chk("b2b_a_ready", 64'(ready), 64'd1);
      req(1'b1, 32'h1000_2020, 32'h2222_2222);
      expect_rsp(1'b1, 32'h0);
      tick();
      transfer = 1'b0;
      chk("b2b_b_psel",    64'(PSEL),    64'h4);
      chk("b2b_b_penable", 64'(PENABLE), 64'd0);
      chk("b2b_b_paddr",   64'(PADDR),   64'h1000_2020);
      chk("b2b_b_pwdata",  64'(PWDATA),  64'h2222_2222);
      tick();
      chk("b2b_b_ready", 64'(ready), 64'd1);
      chk("b2b_b_err",   64'(err),   64'd1);
      tick();
      PSLVERR = '0;
      chk("b2b_idle_psel", 64'(PSEL), 64'd0);
      addr = 32'hFFFF_FFFF;
      tick();
      chk("idle_hold_paddr", 64'(PADDR), 64'h1000_2020);

      // Reset mid-ACCESS aborts silently; the next read completes.
      PREADY = '0;
      req(1'b0, 32'h1000_1000, 32'h5555_5555);
      tick();
      transfer = 1'b0;
      tick();
      chk("ra_acc_penable", 64'(PENABLE), 64'd1);
      #2 PRESET = 1'b0;
      #1;
      chk("ra_psel",    64'(PSEL),    64'd0);
      chk("ra_penable", 64'(PENABLE), 64'd0);
      chk("ra_paddr",   64'(PADDR),   64'd0);
      chk("ra_pwdata",  64'(PWDATA),  64'd0);
      chk("ra_ready",   64'(ready),   64'd0);
      tick();
      PRESET = 1'b1;
      tick();
      PREADY = 4'b0010;
      PRDATA[1*DW +: DW] = 32'h1234_5678;
      req(1'b0, 32'h1000_1008, 32'h0);
      expect_rsp(1'b0, 32'h1234_5678);
      tick();
      transfer = 1'b0;
      chk("ra_next_paddr", 64'(PADDR), 64'h1000_1008);
      tick();
      chk("ra_next_ready", 64'(ready), 64'd1);
      tick();

      // Slave0 never ready: timeout build aborts, default build keeps waiting.
      PREADY = '0;
      PRDATA[0*DW +: DW] = 32'h0000_0077;
`ifdef APB_BRIDGE_TIMEOUT_EN
      req(1'b0, 32'h1000_0000, 32'h0);
      expect_rsp(1'b1, 32'h0);
      tick();
      transfer = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("to_ready", 64'(ready), (i == 5) ? 64'd1 : 64'd0);
         chk("to_err",   64'(err),   (i == 5) ? 64'd1 : 64'd0);
      end
      tick();
      chk("to_psel", 64'(PSEL), 64'd0);
`else
      req(1'b0, 32'h1000_0000, 32'h0);
      expect_rsp(1'b0, 32'h0000_0077);
      tick();
      transfer = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("wait_ready", 64'(ready), 64'd0);
      end
      chk("wait_psel", 64'(PSEL), 64'h1);
      tick();
      PREADY = 4'b0001;
      #1;
      chk("wait_done_ready", 64'(ready), 64'd1);
      tick();
      PREADY = '0;
      chk("wait_idle_psel", 64'(PSEL), 64'd0);
`endif

      repeat (3) tick();
      chk("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
